g_perm_arbiter: RTL
===================

Name: g_perm_arbiter

Overview:
Shares one G permutation core between two sponge-phase requesters: port 0 is absorb and port 1 is squeeze. The block arbitrates round-robin and latches the winner's capacity and round count. It then sequences the core's enable/reset, captures rout/cout, and returns a one-cycle done pulse to the granted requester. It sits between the absorb/squeeze FSMs and the single G instance, replacing the per-phase private G.

Parameters:
CWIDTH, 320, capacity width (G c/cout)
RWIDTH, 32, rate output width (G rout)
ROUND_COUNT, 10, width of rounds field
TIMEOUT, 1024, max BUSY cycles before a job is abandoned (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
req0 / req1  in  1  job request, held high until done or abort
c0 / c1  in  CWIDTH  capacity operand per requester
rounds0 / rounds1  in  ROUND_COUNT  round count per requester
done0 / done1  out  1  one-cycle completion pulse to that requester
rout  out  RWIDTH  captured G rate output, shared, valid at done
cout  out  CWIDTH  captured G capacity output, shared, valid at done
grant  out  1  index of the current/last granted requester
busy  out  1  high in BUSY and RESP
timeout  out  1  one-cycle pulse when a job is abandoned
g_c  out  CWIDTH  to G .c
g_rounds  out  ROUND_COUNT  to G .rounds
g_en  out  1  to G .en
g_reset  out  1  to G .reset (high whenever the core is not running a job)
g_rout  in  RWIDTH  from G
g_cout  in  CWIDTH  from G
g_done  in  1  from G

Behaviour:
- Reset (async): state=IDLE, ptr=0, grant=0, all outputs 0 except g_reset=1, wdog=0.
- States: IDLE, BUSY, RESP, ERR. g_en=1 and g_reset=0 only in BUSY (decoded from the registered state).
- IDLE: req sampled only here.
  - One req high: grant it.
  - Both high: grant ptr.
  - On grant: latch g_c<=c[sel] and g_rounds<=rounds[sel], set grant<=sel, clear wdog, next state BUSY.
  - No req: stay in IDLE.
- BUSY: wdog increments each cycle. Priority is abort, then done, then timeout:
  1. req[grant]==0 (abort): next IDLE, no done, ptr<=~grant.
  2. g_done==1: rout<=g_rout, cout<=g_cout, next RESP.
  3. wdog==TIMEOUT-1: next ERR.
- RESP: done[grant]=1 for exactly one cycle, ptr<=~grant, next IDLE.
- ERR: timeout=1 for one cycle, no done, ptr<=~grant, next IDLE. rout/cout unchanged.
- Latency: req seen in IDLE at cycle 0, BUSY from cycle 1. If g_done arrives at cycle k, done is high at cycle k+1. Minimum is 3 cycles (k=1 with a same-cycle G).
- Requester contract: deassert req on the edge after done is seen. IDLE follows RESP, so req still high in IDLE is treated as a new job.
- g_c/g_rounds stay stable for the whole job; mid-job changes to c/rounds inputs are ignored.
- rout/cout hold their last captured value until the next capture.
- Back-to-back jobs: fairness comes from the ptr flip. With both requesters held high, grants alternate 0,1,0,1.
- Reset mid-BUSY: G is reset immediately via g_reset, and no done or timeout is emitted.

Test Plan:
- req0 only, c0=0x…A5, rounds0=10, G done after 12 BUSY cycles -> done0 at cycle 13, rout/cout equal G outputs, done1 never asserted, grant=0.
- req0 and req1 raised same cycle after reset, both re-requesting after done -> grant sequence 0,1,0,1 over four jobs, no done pulse to the wrong port.
- req1 dropped at BUSY cycle 4 -> g_en falls next cycle, no done1, next simultaneous request grants 0.
- TIMEOUT=16, g_done tied 0 -> timeout pulse exactly once after 16 BUSY cycles, state back to IDLE, rout/cout unchanged.
- Async reset asserted mid-BUSY between clock edges -> g_reset=1 and g_en=0 immediately, all outputs 0, ptr=0.
- g_done and req-drop in the same BUSY cycle -> abort wins: no done, rout unchanged.

Source files
------------

// File: rtl/g_perm_arbiter.sv
// Round-robin arbiter sharing one G permutation core between the absorb (port 0)
// and squeeze (port 1) requesters; sequences the core and returns a done pulse.
module g_perm_arbiter #(
   parameter int CWIDTH      = 320,
   parameter int RWIDTH      = 32,
   parameter int ROUND_COUNT = 10,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0,
   input  logic                   req1,
   input  logic [CWIDTH-1:0]      c0,
   input  logic [CWIDTH-1:0]      c1,
   input  logic [ROUND_COUNT-1:0] rounds0,
   input  logic [ROUND_COUNT-1:0] rounds1,
   output logic                   done0,
   output logic                   done1,
   output logic [RWIDTH-1:0]      rout,
   output logic [CWIDTH-1:0]      cout,
   output logic                   grant,
   output logic                   busy,
   output logic                   timeout,
   output logic [CWIDTH-1:0]      g_c,
   output logic [ROUND_COUNT-1:0] g_rounds,
   output logic                   g_en,
   output logic                   g_reset,
   input  logic [RWIDTH-1:0]      g_rout,
   input  logic [CWIDTH-1:0]      g_cout,
   input  logic                   g_done
);

   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_ERR} state_t;

   state_t                 state_q;
   logic                   ptr_q;
   logic                   grant_q;
   logic [WDW-1:0]         wdog_q;
   logic [CWIDTH-1:0]      g_c_q;
   logic [ROUND_COUNT-1:0] g_rounds_q;
   logic [RWIDTH-1:0]      rout_q;
   logic [CWIDTH-1:0]      cout_q;

   logic sel_d;
   logic req_own;

   // With a single requester the pointer is irrelevant; with both, ptr breaks the tie.
   always_comb begin
      sel_d   = (req0 && req1) ? ptr_q : req1;
      req_own = grant_q ? req1 : req0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= 1'b0;
         grant_q    <= 1'b0;
         wdog_q     <= '0;
         g_c_q      <= '0;
         g_rounds_q <= '0;
         rout_q     <= '0;
         cout_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req0 || req1) begin
                  grant_q    <= sel_d;
                  g_c_q      <= sel_d ? c1 : c0;
                  g_rounds_q <= sel_d ? rounds1 : rounds0;
                  wdog_q     <= '0;
                  state_q    <= S_BUSY;
               end
            end
            S_BUSY: begin
               wdog_q <= wdog_q + 1'b1;
               // Abort beats a same-cycle completion: the requester has already left.
               if (!req_own) begin
                  ptr_q   <= ~grant_q;
                  state_q <= S_IDLE;
               end else if (g_done) begin
                  rout_q  <= g_rout;
                  cout_q  <= g_cout;
                  state_q <= S_RESP;
               end else if (wdog_q == WD_LAST) begin
                  state_q <= S_ERR;
               end
            end
            S_RESP, S_ERR: begin
               ptr_q   <= ~grant_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign g_en     = (state_q == S_BUSY);
   assign g_reset  = ~g_en;
   assign busy     = (state_q == S_BUSY) || (state_q == S_RESP);
   assign timeout  = (state_q == S_ERR);
   assign done0    = (state_q == S_RESP) && !grant_q;
   assign done1    = (state_q == S_RESP) &&  grant_q;
   assign grant    = grant_q;
   assign g_c      = g_c_q;
   assign g_rounds = g_rounds_q;
   assign rout     = rout_q;
   assign cout     = cout_q;

endmodule
